// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared funct, select and alu_ctl codes plus sequencer types
package alu_pkg;

    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [1:0] SEL_ALU   = 2'b00;
    localparam logic [1:0] SEL_HI    = 2'b01;
    localparam logic [1:0] SEL_LO    = 2'b10;
    localparam logic [1:0] SEL_SHIFT = 2'b11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } seq_state_e;

    // One decoded op: legal flag, multi-cycle flag, result select and ALU control.
    typedef struct packed {
        logic       legal;
        logic       multi;
        logic [1:0] sel;
        logic [2:0] alu_ctl;
    } dec_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - op issue handshake between requester and sequencer
interface alu_sequencer_if;
    logic       op_valid;
    logic [5:0] funct;
    logic       op_ready;

    modport master (output op_valid, output funct, input op_ready);
    modport slave  (input op_valid, input funct, output op_ready);
endinterface

// File: rtl/mdu_counter.sv
// rtl/mdu_counter.sv - loadable 5-bit down-counter shared by MULTU and DIVU
module mdu_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [4:0] load_val_i,
    output logic [4:0] cnt_o,
    output logic       zero_o
);
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    // Load has priority over decrement so a new sequence always starts clean.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q - 5'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == 5'd0);
endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - ALU control sequencer with multi-cycle MULTU; DIVU via ALU_SEQ_DIVU_EN
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.slave  op_if,
    output logic            result_valid,
    output logic [1:0]      sel,
    output logic [2:0]      alu_ctl,
    output logic            illegal,
    output logic            mul_start,
    output logic            mul_step,
    output logic            hilo_we,
    output logic            busy
`ifdef ALU_SEQ_DIVU_EN
    ,
    output logic            div_mode
`endif
);
    localparam logic [4:0] CNT_LOAD = 5'(MUL_CYCLES - 1);

    function automatic dec_t decode(input logic [5:0] f);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (f)
            FUNCT_AND:   d.alu_ctl = ALU_AND;
            FUNCT_OR:    d.alu_ctl = ALU_OR;
            FUNCT_ADD:   d.alu_ctl = ALU_ADD;
            FUNCT_SUB:   d.alu_ctl = ALU_SUB;
            FUNCT_SLT:   d.alu_ctl = ALU_SLT;
            FUNCT_SLL:   d.sel     = SEL_SHIFT;
            FUNCT_MFHI:  d.sel     = SEL_HI;
            FUNCT_MFLO:  d.sel     = SEL_LO;
            FUNCT_MULTU: d.multi   = 1'b1;
`ifdef ALU_SEQ_DIVU_EN
            FUNCT_DIVU:  d.multi   = 1'b1;
`endif
            default:     d.legal   = 1'b0;
        endcase
        return d;
    endfunction

    seq_state_e state_q, state_d;
    dec_t       dec;
    logic       op_ready;
    logic       accept, start, single;
    logic [4:0] cnt;
    logic       cnt_zero;
    logic       rv_q, ill_q;
    logic [1:0] sel_q;
    logic [2:0] ctl_q;

    assign dec    = decode(op_if.funct);
    assign accept = op_if.op_valid && op_ready;
    assign start  = accept && dec.multi;
    assign single = accept && !dec.multi;

    mdu_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (start),
        .en_i       ((state_q == ST_MUL) && !cnt_zero),
        .load_val_i (CNT_LOAD),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

`ifdef ALU_SEQ_DIVU_EN
    logic div_q, div_d;

    // Divide mode is latched at issue and dropped when the sequence ends.
    always_comb begin
        div_d = div_q;
        if (start) begin
            div_d = (op_if.funct == FUNCT_DIVU);
        end else if ((state_q == ST_MUL) && cnt_zero) begin
            div_d = 1'b0;
        end
    end

    // Divide-mode register.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_d;
        end
    end

    assign div_mode = div_q;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a multi-cycle op starts from IDLE and ends on counter zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_MUL;
            ST_MUL:  if (cnt_zero) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; HI/LO readers and new multiplies wait until HI/LO is written.
    always_comb begin
        op_ready  = 1'b1;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        hilo_we   = 1'b0;
        busy      = 1'b0;
        if (state_q == ST_MUL) begin
            busy      = 1'b1;
            mul_step  = 1'b1;
            mul_start = (cnt == CNT_LOAD);
            hilo_we   = cnt_zero;
            op_ready  = !((op_if.funct == FUNCT_MFHI) ||
                          (op_if.funct == FUNCT_MFLO) || dec.multi);
        end
    end

    assign op_if.op_ready = op_ready;

    // Single-cycle result register; sel/alu_ctl hold between results.
    always_ff @(posedge clk) begin
        if (reset) begin
            rv_q  <= 1'b0;
            ill_q <= 1'b0;
            sel_q <= SEL_ALU;
            ctl_q <= ALU_AND;
        end else begin
            rv_q  <= single;
            ill_q <= single && !dec.legal;
            if (single) begin
                sel_q <= dec.sel;
                ctl_q <= dec.alu_ctl;
            end
        end
    end

    assign result_valid = rv_q;
    assign illegal      = ill_q;
    assign sel          = sel_q;
    assign alu_ctl      = ctl_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;
    localparam int MC = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       result_valid, illegal, mul_start, mul_step, hilo_we, busy;
    logic [1:0] sel;
    logic [2:0] alu_ctl;
`ifdef ALU_SEQ_DIVU_EN
    logic       div_mode;
`endif
    int         n_cmp = 0;
    int         n_mis = 0;
    logic       saw_we;

    alu_sequencer_if bus ();

    alu_sequencer #(.MUL_CYCLES(MC)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_if        (bus),
        .result_valid (result_valid),
        .sel          (sel),
        .alu_ctl      (alu_ctl),
        .illegal      (illegal),
        .mul_start    (mul_start),
        .mul_step     (mul_step),
        .hilo_we      (hilo_we),
        .busy         (busy)
`ifdef ALU_SEQ_DIVU_EN
        ,
        .div_mode     (div_mode)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f);
        bus.op_valid = v;
        bus.funct    = f;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 6'b000000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outs", {result_valid, sel, alu_ctl, illegal, mul_start, mul_step, hilo_we, busy}, 32'h0);
        check("rst_ready", bus.op_ready, 1'b1);

        // ADD
        next(); drive(1'b1, 6'b100000);
        @(negedge clk); check("add_ready", bus.op_ready, 1'b1);
        next(); drive(1'b0, 6'b100000);
        @(negedge clk);
        check("add_res", {result_valid, sel, alu_ctl, illegal}, {1'b1, 2'b00, 3'b010, 1'b0});
        next();
        @(negedge clk);
        check("add_hold", {result_valid, sel, alu_ctl}, {1'b0, 2'b00, 3'b010});

        // SLL then SUB back to back
        next(); drive(1'b1, 6'b000000);
        next(); drive(1'b1, 6'b100010);
        @(negedge clk); check("sll_res", {result_valid, sel, alu_ctl}, {1'b1, 2'b11, 3'b000});
        next(); drive(1'b0, 6'b100010);
        @(negedge clk); check("sub_res", {result_valid, sel, alu_ctl}, {1'b1, 2'b00, 3'b110});
        next();
        @(negedge clk); check("sub_hold", {result_valid, alu_ctl}, {1'b0, 3'b110});

        // MULTU with MFHI offered continuously and OR slipped in underneath
        next(); drive(1'b1, 6'b011001);
        @(negedge clk); check("multu_ready", bus.op_ready, 1'b1);
        for (int k = 1; k <= MC; k++) begin
            next();
            drive(1'b1, (k == 5) ? 6'b100101 : 6'b010000);
            @(negedge clk);
            if (k == 5) check("or_ready", bus.op_ready, 1'b1);
            else        check("mfhi_blocked", bus.op_ready, 1'b0);
            check("mul_busy", {busy, mul_step}, 2'b11);
            check("mul_start", mul_start, (k == 1));
            check("hilo_we", hilo_we, (k == MC));
            check("rv_in_mul", result_valid, (k == 6));
            if (k == 6) check("or_ctl", {sel, alu_ctl}, {2'b00, 3'b001});
        end
        next(); drive(1'b1, 6'b010000);
        @(negedge clk);
        check("mfhi_ready", bus.op_ready, 1'b1);
        check("post_mul", {busy, mul_step, hilo_we}, 3'b000);
        next(); drive(1'b0, 6'b010000);
        @(negedge clk); check("mfhi_res", {result_valid, sel, illegal}, {1'b1, 2'b01, 1'b0});

        // Reset in the middle of a multiply
        next(); drive(1'b1, 6'b011001);
        next(); drive(1'b0, 6'b010000);
        for (int k = 2; k <= 15; k++) next();
        @(negedge clk); check("mid_busy", busy, 1'b1);
        next(); reset = 1'b1;
        next(); reset = 1'b0;
        @(negedge clk);
        check("abort_outs", {busy, mul_step, hilo_we}, 3'b000);
        check("abort_ready", bus.op_ready, 1'b1);
        saw_we = 1'b0;
        for (int k = 0; k < MC + 8; k++) begin
            next();
            @(negedge clk);
            saw_we = saw_we | hilo_we | busy;
        end
        check("abort_no_we", saw_we, 1'b0);

        // Illegal funct after SLL so sel visibly returns to ALU
        next(); drive(1'b1, 6'b000000);
        next(); drive(1'b1, 6'b111111);
        @(negedge clk); check("sll2_sel", sel, 2'b11);
        next(); drive(1'b0, 6'b111111);
        @(negedge clk);
        check("ill_res", {result_valid, illegal, sel, alu_ctl}, {1'b1, 1'b1, 2'b00, 3'b000});
        next();
        @(negedge clk); check("ill_clear", {result_valid, illegal}, 2'b00);

        // MFLO
        next(); drive(1'b1, 6'b010010);
        next(); drive(1'b0, 6'b010010);
        @(negedge clk); check("mflo_res", {result_valid, sel, illegal}, {1'b1, 2'b10, 1'b0});

        // DIVU
`ifdef ALU_SEQ_DIVU_EN
        next(); drive(1'b1, 6'b011011);
        @(negedge clk); check("divu_ready", bus.op_ready, 1'b1);
        for (int k = 1; k <= MC; k++) begin
            next();
            drive(1'b1, 6'b011011);
            @(negedge clk);
            check("divu_blocked", bus.op_ready, 1'b0);
            check("div_mode", {div_mode, busy, mul_step}, 3'b111);
            check("div_start", mul_start, (k == 1));
            check("div_we", hilo_we, (k == MC));
            check("div_rv", result_valid, 1'b0);
        end
        next(); drive(1'b0, 6'b011011);
        @(negedge clk); check("div_end", {div_mode, busy}, 2'b00);
`else
        next(); drive(1'b1, 6'b000000);
        next(); drive(1'b1, 6'b011011);
        @(negedge clk); check("divu_ready", bus.op_ready, 1'b1);
        next(); drive(1'b0, 6'b011011);
        @(negedge clk);
        check("divu_ill", {result_valid, illegal, sel, busy}, {1'b1, 1'b1, 2'b00, 1'b0});
        next();
        @(negedge clk); check("divu_nomul", {busy, mul_step, result_valid}, 3'b000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
